// File: rtl/fixed_to_float_packer.sv
// fixed_to_float_packer
// Converts a signed two's-complement fixed-point value into an IEEE-754
// single-precision word. Normalisation shifts one bit per cycle; both sides
// use a valid/ready handshake and only one item is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   fixed_in is valid
//   in_ready   block can accept (high only while idle)
//   fixed_in   two's-complement fixed value, bit 0 weight 2^-FRACS
//   out_valid  float_out is valid
//   out_ready  consumer accepts float_out
//   float_out  {sign, exp[7:0], mant[22:0]}
module fixed_to_float_packer #(
    parameter int unsigned INTS  = 1,
    parameter int unsigned FRACS = 21,
    parameter int unsigned WIDTH = INTS + FRACS + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   fixed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      float_out
);

    localparam int unsigned TW       = WIDTH + 1;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned FRAC_W   = TW - 1;
    localparam int unsigned EXT_W    = (FRAC_W > MANT_W) ? FRAC_W : MANT_W;
    localparam logic [7:0]  EXP_INIT = 8'(127 + WIDTH - FRACS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_mag;
    logic [7:0]        r_exp;
    logic              r_sign;
    logic [31:0]       r_float;
    logic              r_out_valid;

    state_t            w_state_nxt;
    logic [TW-1:0]     w_mag_nxt;
    logic [7:0]        w_exp_nxt;
    logic              w_sign_nxt;
    logic [31:0]       w_float_nxt;
    logic              w_out_valid_nxt;

    logic [TW-1:0]     w_abs;
    logic [EXT_W-1:0]  w_frac_ext;
    logic [MANT_W-1:0] w_mant;

    // Magnitude fits in TW bits: the most-negative input maps to 2^WIDTH.
    assign w_abs = fixed_in[WIDTH] ? TW'(~fixed_in + TW'(1)) : fixed_in;

    // Bits below the leading one, left-aligned; narrow inputs are zero-padded,
    // wide inputs lose their low bits (truncation toward zero).
    assign w_frac_ext = EXT_W'(r_mag[FRAC_W-1:0]) << (EXT_W - FRAC_W);
    assign w_mant     = w_frac_ext[EXT_W-1 -: MANT_W];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mag       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_float     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mag       <= w_mag_nxt;
            r_exp       <= w_exp_nxt;
            r_sign      <= w_sign_nxt;
            r_float     <= w_float_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_mag_nxt       = r_mag;
        w_exp_nxt       = r_exp;
        w_sign_nxt      = r_sign;
        w_float_nxt     = r_float;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sign_nxt = fixed_in[WIDTH];
                    w_mag_nxt  = w_abs;
                    w_exp_nxt  = EXP_INIT;
                    if (fixed_in == '0) begin
                        // Zero has no leading one; emit +0 directly.
                        w_float_nxt     = '0;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = DONE;
                    end else begin
                        w_state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (r_mag[WIDTH]) begin
                    w_state_nxt = PACK;
                end else begin
                    w_mag_nxt = {r_mag[WIDTH-1:0], 1'b0};
                    w_exp_nxt = r_exp - 8'd1;
                end
            end
            PACK: begin
                w_float_nxt     = {r_sign, r_exp, w_mant};
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign float_out = r_float;

endmodule
